dma_xfer_engine: RTL and testbench

Transfer sequencer directly downstream of the round-robin channel arbiter in the DMA controller. It takes the arbiter's one-hot acknowledge, runs one single-word memory bus transfer for the granted channel, and advances that channel's address and count. When a channel's count expires it pulses terminal count and disarms the channel. The `armed` output is fed back upstream so that only armed channels can request.

---
 rtl/dma_pkg.sv | 38 +++
 rtl/dma_ch_regs.sv | 77 +++++++
 rtl/dma_xfer_engine.sv | 118 +++++++++++
 tb/tb_dma_xfer_engine.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA transfer engine and its channel register file.
package dma_pkg;

    localparam int NCH = 4;
    localparam int CHW = 2;

    localparam logic [NCH-1:0] CH0_OH = 4'b0001;
    localparam logic [NCH-1:0] CH1_OH = 4'b0010;
    localparam logic [NCH-1:0] CH2_OH = 4'b0100;
    localparam logic [NCH-1:0] CH3_OH = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_UPDATE = 2'd2
    } dma_state_t;

    typedef struct packed {
        logic           valid;
        logic [CHW-1:0] idx;
    } ch_sel_t;

    // Anything other than exactly one bit set decodes as invalid.
    function automatic ch_sel_t oh_to_idx(input logic [NCH-1:0] oh);
        ch_sel_t sel;
        sel.valid = 1'b1;
        sel.idx   = '0;
        case (oh)
            CH0_OH:  sel.idx = 2'd0;
            CH1_OH:  sel.idx = 2'd1;
            CH2_OH:  sel.idx = 2'd2;
            CH3_OH:  sel.idx = 2'd3;
            default: sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dma_ch_regs.sv
// Per-channel address/count/direction/armed registers with a config write port,
// a post-transfer update port and a read mux on the active channel.
module dma_ch_regs
    import dma_pkg::*;
#(
    parameter int AW = 16,
    parameter int CW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [AW-1:0]  wr_addr,
    input  logic [CW-1:0]  wr_cnt,
    input  logic           wr_dir,
    input  logic           upd_en,
    input  logic [CHW-1:0] upd_ch,
    input  logic [CHW-1:0] rd_ch,
    output logic [AW-1:0]  rd_addr,
    output logic [CW-1:0]  rd_cnt,
    output logic           rd_dir,
    output logic [NCH-1:0] armed
);

    logic [AW-1:0]  addr_q [NCH];
    logic [AW-1:0]  addr_d [NCH];
    logic [CW-1:0]  cnt_q  [NCH];
    logic [CW-1:0]  cnt_d  [NCH];
    logic [NCH-1:0] dir_q, dir_d;
    logic [NCH-1:0] armed_q, armed_d;

    // The engine never lets a write and an update target the same channel,
    // so the two ports can be applied independently.
    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        armed_d = armed_q;
        if (upd_en) begin
            addr_d[upd_ch] = addr_q[upd_ch] + AW'(1);
            cnt_d[upd_ch]  = cnt_q[upd_ch] - CW'(1);
            if (cnt_q[upd_ch] == '0) begin
                armed_d[upd_ch] = 1'b0;
            end
        end
        if (wr_en) begin
            addr_d[wr_ch]  = wr_addr;
            cnt_d[wr_ch]   = wr_cnt;
            dir_d[wr_ch]   = wr_dir;
            armed_d[wr_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                addr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            dir_q   <= '0;
            armed_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                addr_q[i] <= addr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            dir_q   <= dir_d;
            armed_q <= armed_d;
        end
    end

    assign rd_addr = addr_q[rd_ch];
    assign rd_cnt  = cnt_q[rd_ch];
    assign rd_dir  = dir_q[rd_ch];
    assign armed   = armed_q;

endmodule

// File: rtl/dma_xfer_engine.sv
// Runs one single-word bus transfer per arbiter grant and retires channels on terminal count.
//   state     | meaning
//   IDLE      | waiting for a one-hot grant to an armed channel
//   XFER      | bus request held for the active channel until mem_ready
//   UPDATE    | advance addr/cnt of the active channel, disarm on terminal count
module dma_xfer_engine
    import dma_pkg::*;
#(
    parameter int AW = 16,
    parameter int CW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] dack,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [CW-1:0]  cfg_cnt,
    input  logic           cfg_dir,
    output logic           mem_valid,
    input  logic           mem_ready,
    output logic [AW-1:0]  mem_addr,
    output logic           mem_we,
    output logic [NCH-1:0] armed,
    output logic           busy,
    output logic [NCH-1:0] tc,
    output logic           cfg_err
);

    dma_state_t     state_q, state_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [NCH-1:0] tc_q, tc_d;
    logic           cfg_err_q, cfg_err_d;

    ch_sel_t        grant;
    logic           cfg_reject;
    logic           cfg_accept;
    logic           upd_en;
    logic [AW-1:0]  rd_addr;
    logic [CW-1:0]  rd_cnt;
    logic           rd_dir;

    assign grant      = oh_to_idx(dack);
    assign cfg_reject = cfg_we && (state_q != ST_IDLE) && (cfg_ch == ch_q);
    assign cfg_accept = cfg_we && !cfg_reject;

    dma_ch_regs #(
        .AW(AW),
        .CW(CW)
    ) u_ch_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cfg_accept),
        .wr_ch   (cfg_ch),
        .wr_addr (cfg_addr),
        .wr_cnt  (cfg_cnt),
        .wr_dir  (cfg_dir),
        .upd_en  (upd_en),
        .upd_ch  (ch_q),
        .rd_ch   (ch_q),
        .rd_addr (rd_addr),
        .rd_cnt  (rd_cnt),
        .rd_dir  (rd_dir),
        .armed   (armed)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        tc_d      = '0;
        cfg_err_d = cfg_reject;
        upd_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant.valid && armed[grant.idx]) begin
                    ch_d    = grant.idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // tc is registered here so it lines up with the UPDATE cycle.
                if (mem_ready) begin
                    state_d = ST_UPDATE;
                    if (rd_cnt == '0) begin
                        tc_d = CH0_OH << ch_q;
                    end
                end
            end
            ST_UPDATE: begin
                upd_en  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            tc_q      <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            tc_q      <= tc_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign mem_valid = (state_q == ST_XFER);
    assign mem_addr  = mem_valid ? rd_addr : '0;
    assign mem_we    = mem_valid & rd_dir;
    assign busy      = (state_q != ST_IDLE);
    assign tc        = tc_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Self-checking bench for dma_xfer_engine against a transaction-level channel model.
module tb_dma_xfer_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  dack = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_addr = '0;
    logic [15:0] cfg_cnt = '0;
    logic        cfg_dir = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [3:0]  armed;
    logic        busy;
    logic [3:0]  tc;
    logic        cfg_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] m_addr [4];
    logic [15:0] m_cnt  [4];
    logic        m_dir  [4];
    logic        m_armed[4];

    always #5 clk = ~clk;

    dma_xfer_engine #(.AW(16), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .dack(dack),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_cnt(cfg_cnt), .cfg_dir(cfg_dir),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .armed(armed), .busy(busy), .tc(tc), .cfg_err(cfg_err)
    );

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = '0; m_cnt[i] = '0; m_dir[i] = 1'b0; m_armed[i] = 1'b0;
        end
    endtask

    function automatic logic [3:0] m_armed_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_armed[i];
        return v;
    endfunction

    // One completed transfer on channel idx; returns the expected tc vector.
    function automatic logic [3:0] model_xfer(int idx);
        logic [3:0] t;
        t = '0;
        if (m_cnt[idx] == 16'd0) begin
            t[idx] = 1'b1;
            m_armed[idx] = 1'b0;
        end
        m_addr[idx] = m_addr[idx] + 16'd1;
        m_cnt[idx]  = m_cnt[idx] - 16'd1;
        return t;
    endfunction

    task automatic do_cfg(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] n,
                          input logic d, input logic exp_rej);
        cfg_we = 1'b1; cfg_ch = ch; cfg_addr = a; cfg_cnt = n; cfg_dir = d;
        @(negedge clk);
        cfg_we = 1'b0;
        tests_run++;
        if (cfg_err !== exp_rej) begin
            tests_failed++;
            $display("FAIL cfg_err ch%0d: got %b exp %b", ch, cfg_err, exp_rej);
        end
        if (!exp_rej) begin
            m_addr[ch] = a; m_cnt[ch] = n; m_dir[ch] = d; m_armed[ch] = 1'b1;
        end
    endtask

    // Engine must be IDLE on entry; returns with engine IDLE.
    task automatic grant(input logic [3:0] oh, input int stall);
        int idx;
        logic go;
        logic [15:0] ea;
        logic [3:0] etc;
        idx = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) idx = i;
        go = ($countones(oh) == 1) && m_armed[idx];
        dack = oh; mem_ready = 1'b0;
        @(negedge clk);
        dack = ~oh;
        tests_run++;
        if (mem_valid !== go || busy !== go) begin
            tests_failed++;
            $display("FAIL grant_start dack=%b: valid=%b busy=%b exp %b", oh, mem_valid, busy, go);
        end
        if (!go) begin
            dack = '0;
        end else begin
            ea = m_addr[idx];
            tests_run++;
            if (mem_addr !== ea || mem_we !== m_dir[idx]) begin
                tests_failed++;
                $display("FAIL xfer_addr ch%0d: addr=%h we=%b exp %h %b", idx, mem_addr, mem_we, ea, m_dir[idx]);
            end
            repeat (stall) begin
                @(negedge clk);
                tests_run++;
                if (mem_valid !== 1'b1 || mem_addr !== ea || mem_we !== m_dir[idx]) begin
                    tests_failed++;
                    $display("FAIL stall_hold ch%0d: valid=%b addr=%h exp 1 %h", idx, mem_valid, mem_addr, ea);
                end
            end
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0; dack = '0;
            etc = model_xfer(idx);
            tests_run++;
            if (tc !== etc || mem_valid !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL update ch%0d: tc=%b valid=%b busy=%b exp tc=%b 0 1", idx, tc, mem_valid, busy, etc);
            end
            @(negedge clk);
            tests_run++;
            if (tc !== 4'b0 || busy !== 1'b0 || armed !== m_armed_vec()) begin
                tests_failed++;
                $display("FAIL back_idle ch%0d: tc=%b busy=%b armed=%b exp 0 0 %b", idx, tc, busy, armed, m_armed_vec());
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({mem_valid, mem_addr, mem_we, armed, busy, tc, cfg_err} !== 28'd0) begin
            tests_failed++;
            $display("FAIL reset_vals: valid=%b addr=%h we=%b armed=%b busy=%b tc=%b err=%b exp all 0",
                     mem_valid, mem_addr, mem_we, armed, busy, tc, cfg_err);
        end
    endtask

    task automatic test_burst();
        int hs_cyc[$];
        logic [15:0] hs_addr[$];
        logic hs_we[$];
        logic [15:0] exp_addr[$];
        logic [3:0] exp_tc;
        int tc_cnt, tc_cyc;
        logic [3:0] tc_val;
        tc_cnt = 0; tc_cyc = -1; tc_val = '0; exp_tc = '0;
        do_cfg(2'd1, 16'h1000, 16'd2, 1'b1, 1'b0);
        while (m_armed[1]) begin
            exp_addr.push_back(m_addr[1]);
            exp_tc = model_xfer(1);
        end
        dack = 4'b0010; mem_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (mem_valid) begin
                hs_cyc.push_back(c); hs_addr.push_back(mem_addr); hs_we.push_back(mem_we);
            end
            if (tc !== 4'b0) begin
                tc_cnt++; tc_cyc = c; tc_val = tc;
            end
        end
        dack = '0; mem_ready = 1'b0;
        tests_run++;
        if (hs_addr.size() !== 3) begin
            tests_failed++;
            $display("FAIL burst_count: got %0d transfers exp 3", hs_addr.size());
        end
        for (int i = 0; i < hs_addr.size() && i < exp_addr.size(); i++) begin
            tests_run++;
            if (hs_addr[i] !== exp_addr[i] || hs_we[i] !== 1'b1) begin
                tests_failed++;
                $display("FAIL burst_xfer%0d: addr=%h we=%b exp %h 1", i, hs_addr[i], hs_we[i], exp_addr[i]);
            end
            if (i > 0) begin
                tests_run++;
                if (hs_cyc[i] - hs_cyc[i-1] !== 3) begin
                    tests_failed++;
                    $display("FAIL burst_spacing%0d: got %0d exp 3", i, hs_cyc[i] - hs_cyc[i-1]);
                end
            end
        end
        tests_run++;
        if (tc_cnt !== 1 || tc_val !== exp_tc || hs_cyc.size() < 3 || tc_cyc !== hs_cyc[hs_cyc.size()-1] + 1) begin
            tests_failed++;
            $display("FAIL burst_tc: count=%0d val=%b cyc=%0d exp 1 %b after last transfer", tc_cnt, tc_val, tc_cyc, exp_tc);
        end
        tests_run++;
        if (armed !== m_armed_vec() || armed[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_disarm: armed=%b exp %b", armed, m_armed_vec());
        end
    endtask

    task automatic test_stall();
        do_cfg(2'd0, 16'h0ABC, 16'd0, 1'b0, 1'b0);
        grant(4'b0001, 5);
    endtask

    task automatic test_ignored();
        grant(4'b0101, 0);
        grant(4'b0100, 0);
        @(negedge clk);
        tests_run++;
        if (mem_valid !== 1'b0 || busy !== 1'b0 || armed[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_grant: valid=%b busy=%b armed2=%b exp 0 0 0", mem_valid, busy, armed[2]);
        end
    endtask

    task automatic test_cfg_reject();
        logic [3:0] etc;
        do_cfg(2'd3, 16'h3A50, 16'd1, 1'b0, 1'b0);
        dack = 4'b1000; mem_ready = 1'b0;
        @(negedge clk);
        dack = '0;
        do_cfg(2'd3, 16'hBEEF, 16'd7, 1'b1, 1'b1);
        do_cfg(2'd0, 16'h0C00, 16'd4, 1'b1, 1'b0);
        tests_run++;
        if (armed[0] !== 1'b1 || mem_valid !== 1'b1 || mem_addr !== 16'h3A50 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reject_hold: armed0=%b valid=%b addr=%h we=%b exp 1 1 3a50 0", armed[0], mem_valid, mem_addr, mem_we);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        etc = model_xfer(3);
        tests_run++;
        if (tc !== etc || cfg_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reject_update: tc=%b err=%b exp %b 0", tc, cfg_err, etc);
        end
        @(negedge clk);
        grant(4'b1000, 0);
        grant(4'b0001, 1);
    endtask

    task automatic test_wrap();
        do_cfg(2'd2, 16'hFFFF, 16'd1, 1'b1, 1'b0);
        grant(4'b0100, 0);
        grant(4'b0100, 2);
        tests_run++;
        if (m_addr[2] !== 16'h0001 || armed[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_end: model addr=%h armed2=%b exp 0001 0", m_addr[2], armed[2]);
        end
    endtask

    task automatic test_random();
        logic [3:0] oh;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) < 4) begin
                do_cfg(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'b0);
            end else begin
                if ($urandom_range(0, 9) < 7) oh = 4'd1 << $urandom_range(0, 3);
                else oh = 4'($urandom_range(0, 15));
                grant(oh, int'($urandom_range(0, 3)));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_cfg(2'd2, 16'h5555, 16'd0, 1'b1, 1'b0);
        dack = 4'b0100; mem_ready = 1'b0;
        @(negedge clk);
        dack = '0;
        tests_run++;
        if (mem_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_start: valid=%b exp 1", mem_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem_valid !== 1'b0 || armed !== 4'b0 || busy !== 1'b0 || tc !== 4'b0 || mem_addr !== 16'h0) begin
            tests_failed++;
            $display("FAIL rstmid_async: valid=%b armed=%b busy=%b tc=%b addr=%h exp all 0", mem_valid, armed, busy, tc, mem_addr);
        end
        model_reset();
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        tests_run++;
        if (tc !== 4'b0 || busy !== 1'b0 || armed !== 4'b0 || mem_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_after: tc=%b busy=%b armed=%b valid=%b exp all 0", tc, busy, armed, mem_valid);
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_stall();
        test_ignored();
        test_cfg_reject();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
